// File: rtl/sym_deser_pkg.sv
// Shared constants and helpers for the symbol deserialiser.
package sym_deser_pkg;

    localparam int DEF_SYM_W  = 2;
    localparam int DEF_WORD_W = 8;
    // Symbols per word for the default configuration.
    localparam int N          = DEF_WORD_W / DEF_SYM_W;
    // Width of the symbol count field (must hold the value N itself).
    localparam int SYMS_W     = $clog2(N) + 1;

    // Width of a count that ranges 0..n inclusive.
    function automatic int syms_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Lowest bit index of symbol slot idx inside a word.
    function automatic int slot_lo(input int idx, input int sym_w,
                                   input int word_w, input bit msb_first);
        if (msb_first) begin
            return word_w - (idx + 1) * sym_w;
        end
        return idx * sym_w;
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// One-word valid/ready output register: load, hold while stalled, drain on ready.
module deser_out_reg
    import sym_deser_pkg::*;
#(
    parameter int DATA_W     = DEF_WORD_W,
    parameter int OUT_SYMS_W = SYMS_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_W-1:0]     i_data,
    input  logic [OUT_SYMS_W-1:0] i_syms,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_data,
    output logic [OUT_SYMS_W-1:0] o_syms,
    output logic                  o_free
);

    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;
    logic [OUT_SYMS_W-1:0] r_syms;

    // Register may take a new word when empty or emptying this cycle.
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_syms  = r_syms;

    // Load has priority over drain so back-to-back words keep valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_syms  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_syms  <= i_syms;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sym_deser.sv
// Collects SYM_W-bit symbols into WORD_W-bit words with early flush support.
module sym_deser
    import sym_deser_pkg::*;
#(
    parameter int SYM_W     = DEF_SYM_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SYM_W-1:0]              sym_in,
    input  logic                          sym_valid,
    output logic                          sym_ready,
    input  logic                          flush,
    output logic                          flush_ack,
    output logic [WORD_W-1:0]             word_out,
    output logic [$clog2(WORD_W/SYM_W):0] word_syms,
    output logic                          word_valid,
    input  logic                          word_ready
);

    localparam int              L_N    = WORD_W / SYM_W;
    localparam int              L_CW   = syms_width(L_N);
    localparam logic [L_CW-1:0] L_LAST = L_CW'(L_N - 1);
    localparam logic [L_CW-1:0] L_FULL = L_CW'(L_N);

    logic [L_CW-1:0]   r_cnt;
    logic [WORD_W-1:0] r_asm;
    logic              r_ack;
    logic              r_flush_done;

    logic              w_out_free;
    logic              w_last;
    logic              w_accept;
    logic              w_complete;
    logic              w_flush_go;
    logic              w_load;
    logic [L_CW-1:0]   w_load_syms;
    logic [WORD_W-1:0] w_asm_ins;
    logic [L_N-1:0]    w_hit;

    assign w_last = (r_cnt == L_LAST);

    // Final symbol or a flush waits only while the output register is blocked.
    assign sym_ready = rst_n
                     && !(w_last && !w_out_free)
                     && !(flush && !w_out_free);

    assign w_accept   = sym_valid && sym_ready;
    assign w_complete = w_accept && w_last;

    // A held flush request is executed once; it re-arms only after flush drops.
    assign w_flush_go = flush && w_out_free && !r_flush_done;

    // A word is emitted on completion, or on flush when it holds any symbol.
    assign w_load = w_complete || (w_flush_go && ((r_cnt != '0) || w_accept));

    assign w_load_syms = w_complete ? L_FULL
                                    : r_cnt + {{(L_CW-1){1'b0}}, w_accept};

    // Assembly word with the current symbol dropped into slot r_cnt.
    genvar gi;
    generate
        for (gi = 0; gi < L_N; gi++) begin : g_slot
            localparam int LO = slot_lo(gi, SYM_W, WORD_W, MSB_FIRST);
            assign w_hit[gi] = w_accept && (r_cnt == L_CW'(gi));
            assign w_asm_ins[LO +: SYM_W] = w_hit[gi] ? sym_in
                                                      : r_asm[LO +: SYM_W];
        end
    endgenerate

    // Symbol counter, assembly register and flush handshake state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_asm        <= '0;
            r_ack        <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_ack <= w_flush_go;
            if (!flush) begin
                r_flush_done <= 1'b0;
            end else if (w_flush_go) begin
                r_flush_done <= 1'b1;
            end
            if (w_load) begin
                r_cnt <= '0;
                r_asm <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + L_CW'(1);
                r_asm <= w_asm_ins;
            end
        end
    end

    assign flush_ack = r_ack;

    deser_out_reg #(
        .DATA_W     (WORD_W),
        .OUT_SYMS_W (L_CW)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (w_asm_ins),
        .i_syms  (w_load_syms),
        .i_ready (word_ready),
        .o_valid (word_valid),
        .o_data  (word_out),
        .o_syms  (word_syms),
        .o_free  (w_out_free)
    );

endmodule

// File: tb/tb_sym_deser.sv
// Scoreboard bench: stimulus pushes expected words, a monitor pops and compares.
module tb_sym_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       flush;
    logic       word_ready;

    logic       m_ready, l_ready, m_ack, l_ack, m_valid, l_valid;
    logic [7:0] m_word, l_word;
    logic [2:0] m_syms, l_syms;

    int n_checks = 0;
    int n_fail   = 0;
    int n_words  = 0;

    typedef struct packed {
        logic [7:0] wm;
        logic [7:0] wl;
        logic [2:0] syms;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    sym_deser #(.SYM_W(2), .WORD_W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(m_ready), .flush(flush), .flush_ack(m_ack),
        .word_out(m_word), .word_syms(m_syms), .word_valid(m_valid),
        .word_ready(word_ready)
    );

    sym_deser #(.SYM_W(2), .WORD_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(l_ready), .flush(flush), .flush_ack(l_ack),
        .word_out(l_word), .word_syms(l_syms), .word_valid(l_valid),
        .word_ready(word_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] wm, input logic [7:0] wl, input logic [2:0] s);
        exp_t e;
        e.wm   = wm;
        e.wl   = wl;
        e.syms = s;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one symbol and hold it until accepted (bounded wait).
    task automatic send(input logic [1:0] s);
        int t;
        t = 0;
        sym_in    = s;
        sym_valid = 1'b1;
        @(negedge clk);
        while (!m_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!m_ready) chk("send_timeout", 32'd0, 32'd1);
        chk("ready_match", l_ready, m_ready);
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
    endtask

    // Monitor: every output handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && m_valid && word_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %h expected none", m_word);
            end else begin
                mon_e = q.pop_front();
                chk("word_msb", m_word, mon_e.wm);
                chk("word_lsb", l_word, mon_e.wl);
                chk("syms_msb", m_syms, mon_e.syms);
                chk("syms_lsb", l_syms, mon_e.syms);
                chk("valid_lsb", l_valid, 1);
                n_words++;
                $display("word %0d: msb=%h lsb=%h syms=%0d", n_words, m_word, l_word, m_syms);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        sym_in     = 2'b00;
        sym_valid  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b1;
        repeat (3) step();

        // Reset state
        @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_word", m_word, 0);
        chk("rst_syms", m_syms, 0);
        chk("rst_ack", m_ack, 0);
        chk("rst_ready", m_ready, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", m_ready, 1);
        step();

        // Full word, both packing orders
        push(8'hC9, 8'h63, 3'd4);
        send(2'b11); send(2'b00); send(2'b10); send(2'b01);
        @(negedge clk);
        chk("t1_valid_rise", m_valid, 1);
        step();
        @(negedge clk);
        chk("t1_valid_fall", m_valid, 0);
        step();

        // Output stall with back-pressure on the last symbol
        word_ready = 1'b0;
        push(8'h55, 8'h55, 3'd4);
        push(8'h55, 8'h55, 3'd4);
        for (int i = 0; i < 7; i++) send(2'b01);
        sym_in    = 2'b01;
        sym_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall_ready", m_ready, 0);
            chk("t3_hold_valid", m_valid, 1);
            chk("t3_hold_word", m_word, 8'h55);
            chk("t3_hold_syms", m_syms, 4);
        end
        step();
        word_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_resume", m_ready, 1);
        step();
        sym_valid = 1'b0;
        @(negedge clk);
        chk("t3_second_valid", m_valid, 1);
        step();
        @(negedge clk);
        chk("t3_drained", m_valid, 0);
        step();

        // Partial flush, then a fresh word from slot 0
        push(8'h60, 8'h09, 3'd2);
        send(2'b01); send(2'b10);
        flush = 1'b1;
        @(negedge clk);
        chk("t4_ack_not_yet", m_ack, 0);
        step();
        @(negedge clk);
        chk("t4_ack", m_ack, 1);
        chk("t4_ack_lsb", l_ack, 1);
        chk("t4_valid", m_valid, 1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t4_ack_single", m_ack, 0);
        chk("t4_valid_fall", m_valid, 0);
        step();
        push(8'hD5, 8'h57, 3'd4);
        send(2'b11); send(2'b01); send(2'b01); send(2'b01);
        @(negedge clk);
        step();

        // Flush with nothing collected
        flush = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t5_ack", m_ack, 1);
        chk("t5_no_word", m_valid, 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_ack_single", m_ack, 0);
        step();

        // Flush while the output register is stalled
        word_ready = 1'b0;
        push(8'h9C, 8'h36, 3'd4);
        push(8'h40, 8'h01, 3'd1);
        send(2'b10); send(2'b01); send(2'b11); send(2'b00);
        send(2'b01);
        flush = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_stall_ready", m_ready, 0);
            chk("t6_no_ack", m_ack, 0);
        end
        step();
        word_ready = 1'b1;
        @(negedge clk);
        chk("t6_ack_late", m_ack, 0);
        step();
        @(negedge clk);
        chk("t6_ack", m_ack, 1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t6_drained", m_valid, 0);
        step();

        // Reset mid-word discards the partial word
        send(2'b11); send(2'b11); send(2'b11);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t7_ready_in_rst", m_ready, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_valid", m_valid, 0);
        chk("t7_word", m_word, 0);
        chk("t7_syms", m_syms, 0);
        chk("t7_ack", m_ack, 0);
        step();
        push(8'hAA, 8'hAA, 3'd4);
        send(2'b10); send(2'b10); send(2'b10); send(2'b10);
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t7_drained", m_valid, 0);

        repeat (3) step();
        chk("queue_empty", q.size(), 0);
        chk("word_count", n_words, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
